pll_seq: RTL

PLL bring-up and reconfiguration sequencer for the GW1NZ-1 rPLL. Runs on the 27 MHz board clock that also feeds the PLL, so it never depends on the clock it controls. It drives the PLL reset and the dynamic IDSEL/FBDSEL/ODSEL divider selects, and qualifies LOCK. It releases the downstream system reset only after lock has been stable, and lets software-side logic request a new divider setting at runtime.

---
 rtl/pll_seq_pkg.sv | 42 ++++
 rtl/sync_2ff.sv | 41 ++++
 rtl/pll_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
//
// Shared types and constants for the GW1NZ-1 rPLL bring-up sequencer.
//   pll_seq_state_t : sequencer state encoding
//   pll_sel_t       : one 6-bit raw dynamic divider select code
//   pll_sel_set_t   : the IDSEL/FBDSEL/ODSEL triple as one register
//   PLL72_*         : divider codes for 72 MHz out of the 27 MHz board clock
//   max3()          : helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_WAIT = 3'd1,
        ST_STAB = 3'd2,
        ST_RUN  = 3'd3,
        ST_FAIL = 3'd4
    } pll_seq_state_t;

    typedef logic [5:0] pll_sel_t;

    typedef struct packed {
        pll_sel_t idsel;
        pll_sel_t fbdsel;
        pll_sel_t odsel;
    } pll_sel_set_t;

    // 27 MHz / 3 * 8 = 72 MHz, output divider 8 keeps the VCO at 576 MHz.
    localparam pll_sel_t PLL72_IDSEL  = 6'd2;
    localparam pll_sel_t PLL72_FBDSEL = 6'd7;
    localparam pll_sel_t PLL72_ODSEL  = 6'd8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Generic two-flop synchronizer for slow or level signals crossing into the
// clk_i domain. Not suitable for multi-bit buses whose bits must stay
// coherent; each bit resolves independently.
//
// Ports:
//   clk_i   in  1     : destination clock
//   rst_ni  in  1     : asynchronous active-low reset
//   d_i     in  WIDTH : asynchronous input
//   q_o     out WIDTH : synchronized output (2 clk_i cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs from before the edge and the chain stays two deep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_seq.sv
// ---------------------------------------------------------------------------
// pll_seq
//
// Bring-up and reconfiguration sequencer for the GW1NZ-1 rPLL. Clocked by
// the 27 MHz reference that also feeds the PLL, so it never depends on the
// clock it controls. Holds the PLL in reset, waits for LOCK, qualifies it
// for STABLE_CYCLES, then releases the downstream reset. A level request
// in RUN (or FAIL) loads new divider selects and restarts the sequence.
//
// Optional feature: define PLL_SEQ_LOCK_TIMEOUT_EN to bound the lock wait.
// Each timeout re-issues a PLL reset; after MAX_RETRY timeouts the block
// parks in FAIL until cfg_req or rst_n. Without the macro WAIT waits
// forever and fail is tied low.
//
// Ports:
//   clkin       in  1 : 27 MHz reference, the only clock
//   rst_n       in  1 : asynchronous active-low reset
//   pll_lock    in  1 : raw rPLL LOCK, asynchronous to clkin
//   cfg_req     in  1 : level reconfiguration request, held until cfg_ack
//   cfg_idsel   in  6 : new IDSEL code
//   cfg_fbdsel  in  6 : new FBDSEL code
//   cfg_odsel   in  6 : new ODSEL code
//   cfg_ack     out 1 : one-cycle pulse when the request is accepted
//   pll_reset   out 1 : rPLL RESET
//   pll_idsel   out 6 : rPLL IDSEL
//   pll_fbdsel  out 6 : rPLL FBDSEL
//   pll_odsel   out 6 : rPLL ODSEL
//   sys_rst_n   out 1 : downstream active-low reset, high only in RUN
//   locked      out 1 : high only in RUN
//   fail        out 1 : high only in FAIL
// ---------------------------------------------------------------------------
module pll_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRY      = 3,
    parameter pll_sel_t    DEF_IDSEL      = 6'd0,
    parameter pll_sel_t    DEF_FBDSEL     = 6'd0,
    parameter pll_sel_t    DEF_ODSEL      = 6'd0
) (
    input  logic     clkin,
    input  logic     rst_n,
    input  logic     pll_lock,
    input  logic     cfg_req,
    input  pll_sel_t cfg_idsel,
    input  pll_sel_t cfg_fbdsel,
    input  pll_sel_t cfg_odsel,
    output logic     cfg_ack,
    output logic     pll_reset,
    output pll_sel_t pll_idsel,
    output pll_sel_t pll_fbdsel,
    output pll_sel_t pll_odsel,
    output logic     sys_rst_n,
    output logic     locked,
    output logic     fail
);

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    localparam bit LOCK_TIMEOUT_EN = 1'b1;
`else
    localparam bit LOCK_TIMEOUT_EN = 1'b0;
`endif

    // One counter serves RST length, STAB qualification and WAIT timeout.
    localparam int unsigned MAX_CYC = max3(RESET_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAB_DONE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    localparam pll_sel_set_t DEF_SEL = {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL};

    pll_seq_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    pll_sel_set_t       sel_q, sel_d;
    logic               ack_d;
    logic               cfg_ack_q, pll_reset_q, sys_rst_n_q, locked_q;
    logic               lock_s;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b0)
    ) u_lock_sync (
        .clk_i (clkin),
        .rst_ni(rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    // Saturating increments: the counter never wraps back into a stale match.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        sel_d   = sel_q;
        ack_d   = 1'b0;

        unique case (state_q)
            ST_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STAB;
                    cnt_d   = '0;
                end else if (LOCK_TIMEOUT_EN) begin
                    if (cnt_q == TO_LAST) begin
                        cnt_d   = '0;
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RST;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_STAB: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_DONE) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                // Lock loss in RUN: the PLL relocks by itself, so no reset.
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase

        // Reconfiguration overrides whatever the state case decided, so a
        // request arriving with lock loss in RUN still goes to RST.
        if (cfg_req && (state_q == ST_RUN || state_q == ST_FAIL)) begin
            state_d = ST_RST;
            cnt_d   = '0;
            retry_d = '0;
            sel_d   = {cfg_idsel, cfg_fbdsel, cfg_odsel};
            ack_d   = 1'b1;
        end
    end

    // Outputs are decoded from state_d so they are registered yet change on
    // the same edge as the state itself.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            sel_q       <= DEF_SEL;
            cfg_ack_q   <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sel_q       <= sel_d;
            cfg_ack_q   <= ack_d;
            pll_reset_q <= (state_d == ST_RST) || (state_d == ST_FAIL);
            sys_rst_n_q <= (state_d == ST_RUN);
            locked_q    <= (state_d == ST_RUN);
        end
    end

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    logic fail_q;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= (state_d == ST_FAIL);
        end
    end

    assign fail = fail_q;
`else
    assign fail = 1'b0;
`endif

    assign cfg_ack    = cfg_ack_q;
    assign pll_reset  = pll_reset_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign locked     = locked_q;
    assign pll_idsel  = sel_q.idsel;
    assign pll_fbdsel = sel_q.fbdsel;
    assign pll_odsel  = sel_q.odsel;

endmodule
